eth_tx_sched: RTL
=================

// Module: eth_tx_sched
// PURPOSE
// Frame scheduler for the single RGMII transmit byte datapath (clk125 domain).
// Round-robin arbitrates NREQ payload sources for the transmitter and sequences each frame:
// preamble+SFD, header, payload, FCS, inter-frame gap. Drives phase/byte index to the datapath
// and the read strobe to the granted source; the datapath keys byte muxing and CRC init/update off them.
// PARAMETERS
// NREQ         4    number of requesters (2..8)
// PRE_LEN      8    preamble+SFD bytes (7x 0x55, 1x 0xD5)
// HDR_LEN      14   MAC header bytes
// PAYLOAD_LEN  200  payload bytes per frame (46..1500)
// IFG_LEN      12   inter-frame gap bytes (>=1)
// PORTS
// clk125        in   1     125 MHz byte clock
// rst_n         in   1     reset, synchronous, active-low
// enable        in   1     level; 0 = finish current frame+IFG, then stay IDLE
// req           in   NREQ  level per source: full frame of payload available
// underrun      in   1     granted source empty while rden=1
// err_clr       in   1     pulse; clears err_underrun
// gnt           out  NREQ  one-hot grant, held from PRE start through last FCS byte
// phase         out  3     phase_t: IDLE, PRE, HDR, PAY, FCS, IFG
// bytecnt       out  11    byte index within current phase, 0-based
// rden          out  1     payload read strobe, =1 exactly when phase==PAY
// txen          out  1     =1 when phase in {PRE,HDR,PAY,FCS} (feeds txctl)
// frame_start   out  1     1-cycle pulse, first PRE byte
// frame_done    out  1     1-cycle pulse, last FCS byte
// err_underrun  out  1     sticky underrun flag
// BEHAVIOUR
// - Reset (rst_n=0 at edge): phase=IDLE, bytecnt=0, gnt=0, rden=0, txen=0, pulses=0,
//   err_underrun=0, rr pointer=0 (source 0 highest priority next). Mid-frame reset aborts at once.
// - Phase lengths: PRE_LEN, HDR_LEN, PAYLOAD_LEN, 4, IFG_LEN. bytecnt counts 0..len-1,
//   returns to 0 on every phase change. Phase advances on the edge after bytecnt==len-1.
// - Frame length PRE+HDR+PAY+4 = 226 cycles at defaults; txen high for exactly that span.
// - Arbitration point: cycle with phase==IDLE, or phase==IFG && bytecnt==IFG_LEN-1.
//   If enable && |req there, next cycle: phase=PRE, bytecnt=0, gnt=winner, frame_start=1.
//   Else IFG->IDLE; IDLE holds. Latency req->frame_start = 1 cycle from IDLE.
// - Back-to-back: start-to-start spacing = frame length + IFG_LEN (238 at defaults); gap never < IFG_LEN.
// - Round robin: search starts at (last winner+1) mod NREQ; pointer updates only on grant.
// - req sampled only at arbitration points; deassertion during own frame is ignored.
// - gnt drops to 0 on the cycle after frame_done (i.e. on entry to IFG).
// - enable sampled only at arbitration points; never truncates a frame in progress.
// - underrun counted only when rden=1; sets err_underrun next cycle; frame length unchanged
//   (datapath pads). err_clr and a new underrun in the same cycle: err_underrun stays 1.
// - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
// - eth_tx_pkg: typedef enum logic[2:0] phase_t; PRE_LEN/HDR_LEN/FCS_LEN/IFG_LEN defaults;
//   SFD=8'hD5, PRE_BYTE=8'h55. Shared with the tx datapath.
// - Sub-module rr_arbiter #(NREQ): req, ptr, advance -> one-hot gnt_next, winner index.
// - Top: phase FSM + 11-bit bytecnt + output registers.
// TESTING
// 1 req=4'b0100 from IDLE -> next cycle gnt=0100, frame_start; PRE 8, HDR 14, PAY 200 (rden 200
//   cycles), FCS 4, frame_done 225 cycles after frame_start, IFG 12 then IDLE.
// 2 req=4'b1111 held -> grants 0001,0010,0100,1000,0001; frame_start spacing exactly 238.
// 3 enable=0 during PAY of frame on src1, req=1111 -> frame completes, IFG, IDLE; no further gnt.
// 4 rst_n=0 at PAY bytecnt=50 -> next cycle all outputs at reset values; after release with
//   req=0010 a full frame on src1 (rr pointer reset).
// 5 underrun pulse at PAY bytecnt=10 -> err_underrun=1 next cycle, frame still 226 cycles;
//   err_clr -> 0; err_clr coincident with underrun -> stays 1.
// 6 PAYLOAD_LEN=46, IFG_LEN=1, req=0001 held -> 72-cycle frames, 1-cycle gap, no IDLE visits.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: phase encoding and frame constants shared by the tx scheduler and byte datapath
package eth_tx_pkg;
  typedef enum logic [2:0] {PH_IDLE, PH_PRE, PH_HDR, PH_PAY, PH_FCS, PH_IFG} phase_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_PRE_LEN = 8;
  localparam int DEF_HDR_LEN = 14;
  localparam int DEF_PAYLOAD_LEN = 200;
  localparam int DEF_IFG_LEN = 12;
  localparam int FCS_LEN = 4;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD = 8'hD5;
endpackage

// File: rtl/eth_tx_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick starting at last winner+1; pointer moves only on advance
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            i_clk125,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt_next
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_winner;
  logic          w_found;
  always_comb begin
    o_gnt_next = '0;
    w_winner = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_winner = w_idx;
        o_gnt_next[w_idx] = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk125) begin
    if (!i_rst_n) r_ptr <= '0;
    else if (i_advance) r_ptr <= (int'(w_winner) == NREQ - 1) ? '0 : w_winner + PW'(1);
  end
endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: frame sequencer (PRE/HDR/PAY/FCS/IFG) with round-robin source grant
module eth_tx_sched
  import eth_tx_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PRE_LEN = DEF_PRE_LEN,
  parameter int HDR_LEN = DEF_HDR_LEN,
  parameter int PAYLOAD_LEN = DEF_PAYLOAD_LEN,
  parameter int IFG_LEN = DEF_IFG_LEN
) (
  input  logic            i_clk125,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_underrun,
  input  logic            i_err_clr,
  output logic [NREQ-1:0] o_gnt,
  output phase_t          o_phase,
  output logic [10:0]     o_bytecnt,
  output logic            o_rden,
  output logic            o_txen,
  output logic            o_frame_start,
  output logic            o_frame_done,
  output logic            o_err_underrun
);
  phase_t          r_phase, w_phase;
  logic [10:0]     r_cnt, w_cnt, w_len;
  logic [NREQ-1:0] r_gnt, w_gnt, w_arb_gnt;
  logic            w_last, w_start, r_fs, r_fd, r_err;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_clk125  (i_clk125),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .i_advance (w_start),
    .o_gnt_next(w_arb_gnt)
  );
  always_comb begin
    w_len = r_phase == PH_PRE ? 11'(PRE_LEN) :
            r_phase == PH_HDR ? 11'(HDR_LEN) :
            r_phase == PH_PAY ? 11'(PAYLOAD_LEN) :
            r_phase == PH_FCS ? 11'(FCS_LEN) :
            r_phase == PH_IFG ? 11'(IFG_LEN) : 11'd1;
    w_last = r_cnt == w_len - 11'd1;
    w_start = (r_phase == PH_IDLE || (r_phase == PH_IFG && w_last)) && i_enable && |i_req;
    w_phase = w_start ? PH_PRE :
              !w_last ? r_phase :
              r_phase == PH_PRE ? PH_HDR :
              r_phase == PH_HDR ? PH_PAY :
              r_phase == PH_PAY ? PH_FCS :
              r_phase == PH_FCS ? PH_IFG : PH_IDLE;
    w_cnt = w_last ? 11'd0 : r_cnt + 11'd1;
    w_gnt = w_start ? w_arb_gnt : (r_phase == PH_FCS && w_last) ? '0 : r_gnt;
  end
  always_ff @(posedge i_clk125) begin
    if (!i_rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt <= '0;
      r_gnt <= '0;
      r_fs <= 1'b0;
      r_fd <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_phase <= w_phase;
      r_cnt <= w_cnt;
      r_gnt <= w_gnt;
      r_fs <= w_start;
      r_fd <= w_phase == PH_FCS && w_cnt == 11'(FCS_LEN - 1);
      r_err <= (r_phase == PH_PAY && i_underrun) || (r_err && !i_err_clr);
    end
  end
  assign o_gnt = r_gnt;
  assign o_phase = r_phase;
  assign o_bytecnt = r_cnt;
  assign o_rden = r_phase == PH_PAY;
  assign o_txen = r_phase inside {PH_PRE, PH_HDR, PH_PAY, PH_FCS};
  assign o_frame_start = r_fs;
  assign o_frame_done = r_fd;
  assign o_err_underrun = r_err;
endmodule
